kc705_ethernet_rgmii_axi_tx_encoder: RTL and testbench
======================================================

Name: kc705_ethernet_rgmii_axi_tx_encoder

Overview:
Transmit-side counterpart of the RX frame decoder. Takes a raw 8-bit AXI-Stream payload, for example from the ADC data FIFO, and prepends an Ethernet header: destination address, source address, optional 802.1Q tag and EtherType. Pads short frames up to the minimum length and truncates frames that exceed the maximum payload. The output AXI-Stream feeds the MAC TX path; the MAC appends the FCS.

Parameters:
DEST_ADDR, 48'h985aebdb066f, destination MAC, sent MSB byte first
SRC_ADDR, 48'h5a0102030405, source MAC, sent MSB byte first
ETHERTYPE, 16'h0800, type field, sent MSB byte first
MAX_SIZE, 16'd1500, maximum payload bytes per frame
MIN_SIZE, 16'd60, minimum frame bytes, header + payload + pad, FCS excluded
ENABLE_VLAN, 1'b0, insert 802.1Q tag when 1
VLAN_ID, 12'd2, VID field
VLAN_PRIORITY, 3'd2, PCP field
Constraint: HDR_LEN + MAX_SIZE >= MIN_SIZE, where HDR_LEN = 14, or 18 with VLAN.

Ports:
axi_tclk  in  1  clock; one clock domain only
axi_treset  in  1  reset, asynchronous, active-high
enable_tx_encode  in  1  permits a new frame to start
s_tdata  in  8  payload byte
s_tvalid  in  1  payload valid
s_tlast  in  1  last payload byte
s_tready  out  1  payload accept
tx_axis_tdata  out  8  frame byte
tx_axis_tvalid  out  1  frame valid
tx_axis_tlast  out  1  last frame byte
tx_axis_tready  in  1  downstream accept
frame_done  out  1  one-cycle pulse on the cycle the final byte is accepted
frame_truncated  out  1  one-cycle pulse when the MAX_SIZE cut-off is applied

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all counters = 0.
  - s_tready, tx_axis_tvalid, tx_axis_tlast, frame_done, frame_truncated = 0; tx_axis_tdata = 0.
  - Reset mid-frame aborts the frame with no tlast. After release, the next frame starts with DA byte 0.
- Transfer rule: a transfer occurs on a clock edge where valid & ready. Output tdata and tlast are held stable while tvalid=1 and tready=0.
- Counters:
  - byte_cnt (16 bit): frame bytes accepted downstream.
  - pay_cnt (16 bit): payload bytes accepted.
  - No wrap is possible, because both are bounded by MAX_SIZE + HDR_LEN.
- IDLE:
  - tx_axis_tvalid = 0, s_tready = 0.
  - If enable_tx_encode & s_tvalid at a clock edge, go to HEADER; the payload byte is not consumed.
  - enable_tx_encode is sampled only in IDLE. Deasserting it mid-frame lets the current frame complete.
- HEADER:
  - tx_axis_tvalid = 1 (registered), s_tready = 0.
  - Byte order: DA[47:40]..DA[7:0], SA[47:40]..SA[7:0].
  - If VLAN enabled, then 8'h81, 8'h00, {PCP, 1'b0, VID[11:8]}, VID[7:0].
  - Then ETHERTYPE[15:8], ETHERTYPE[7:0].
  - Index advances per accepted byte. After byte HDR_LEN-1 is accepted, go to PAYLOAD.
- PAYLOAD: zero-latency pass-through.
  - tx_axis_tdata = s_tdata, tx_axis_tvalid = s_tvalid, s_tready = tx_axis_tready.
  - The MAX_SIZE cut-off has priority over the s_tlast cases below. If the accepted byte is payload number MAX_SIZE and s_tlast = 0: tx_axis_tlast = 1 on that byte, frame_truncated pulses, go to DROP.
  - If the accepted byte has s_tlast = 1 and byte_cnt+1 >= MIN_SIZE: tx_axis_tlast = 1, frame_done pulses, go to IDLE.
  - If the accepted byte has s_tlast = 1 and byte_cnt+1 < MIN_SIZE: tx_axis_tlast = 0, go to PAD.
  - If s_tlast arrives exactly on byte MAX_SIZE, the frame ends normally: no truncation, no DROP.
- PAD:
  - tx_axis_tdata = 8'h00, tx_axis_tvalid = 1, s_tready = 0.
  - tx_axis_tlast = 1 on byte MIN_SIZE. When that byte is accepted, frame_done pulses and the state goes to IDLE.
- DROP:
  - tx_axis_tvalid = 0, s_tready = 1; input bytes are discarded.
  - On accepted s_tlast, frame_done pulses and the state goes to IDLE. frame_done fires once per frame, on either the tlast output or the end of the drop.
- Back-to-back frames: a new frame can start on the cycle after returning to IDLE, so there is a minimum one-cycle gap.

Test Plan:
1. No VLAN, 46-byte payload 0x00..0x2D, tready=1 -> 60 bytes out: 98 5a eb db 06 6f 5a 01 02 03 04 05 08 00, then the payload; tlast on byte 60; frame_done pulses once; no pad.
2. 10-byte payload -> 24 header+payload bytes, then 36 bytes of 0x00; tlast on byte 60; s_tready=0 throughout PAD.
3. MAX_SIZE=500, 600-byte payload -> 514 bytes out with tlast on byte 514; frame_truncated pulses; the remaining 100 input bytes are consumed with tx_axis_tvalid=0; the following frame starts cleanly with byte 0x98.
4. ENABLE_VLAN=1, VID=2, PCP=2, 10-byte payload -> bytes 13-16 are 81 00 40 02, bytes 17-18 are 08 00; padded to 60 bytes.
5. Test 1 with tready pattern 1,0,0,1,0,1 repeating -> output byte sequence identical to test 1; tdata and tlast stable during stalls; no byte duplicated or lost.
6. Reset asserted during output byte 20 -> all outputs 0 immediately (asynchronously); after release with enable=1, s_tvalid=1 -> first byte is 0x98. With enable_tx_encode=0 and s_tvalid=1 held -> s_tready stays 0 and no output.

Source files
------------

// File: rtl/kc705_ethernet_rgmii_axi_tx_encoder.sv
// Ethernet TX framer: prepends DA/SA/(802.1Q)/EtherType to an 8-bit AXI-Stream payload,
// pads short frames with zeros and truncates oversize payloads (MAC appends FCS).
module kc705_ethernet_rgmii_axi_tx_encoder #(
  parameter logic [47:0] DEST_ADDR     = 48'h985aebdb066f,
  parameter logic [47:0] SRC_ADDR      = 48'h5a0102030405,
  parameter logic [15:0] ETHERTYPE     = 16'h0800,
  parameter logic [15:0] MAX_SIZE      = 16'd1500,
  parameter logic [15:0] MIN_SIZE      = 16'd60,
  parameter logic        ENABLE_VLAN   = 1'b0,
  parameter logic [11:0] VLAN_ID       = 12'd2,
  parameter logic [2:0]  VLAN_PRIORITY = 3'd2
) (
  input  logic       axi_tclk,
  input  logic       axi_treset,
  input  logic       enable_tx_encode,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] tx_axis_tdata,
  output logic       tx_axis_tvalid,
  output logic       tx_axis_tlast,
  input  logic       tx_axis_tready,
  output logic       frame_done,
  output logic       frame_truncated
);

  localparam logic [4:0] HDR_LEN = ENABLE_VLAN ? 5'd18 : 5'd14;
  // Header packed MSB-first; the non-VLAN layout leaves 4 unused bytes at the bottom.
  localparam logic [143:0] HDR_BITS = ENABLE_VLAN ?
    {DEST_ADDR, SRC_ADDR, 16'h8100, VLAN_PRIORITY, 1'b0, VLAN_ID, ETHERTYPE} :
    {DEST_ADDR, SRC_ADDR, ETHERTYPE, 32'h0};

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PAD, DROP} state_t;

  state_t      state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;

  function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
    if (idx >= 5'd18) begin
      hdr_byte = 8'h00;
    end else begin
      hdr_byte = HDR_BITS[8'd143 - {idx, 3'b000} -: 8];
    end
  endfunction

  logic        in_pay;
  logic [15:0] byte_inc;
  logic [15:0] pay_inc;
  logic        pay_at_max;
  logic        short_frame;
  logic        tx_xfer;
  logic        pay_xfer;

  assign in_pay      = (state_q == PAYLOAD);
  assign byte_inc    = byte_cnt_q + 16'd1;
  assign pay_inc     = pay_cnt_q + 16'd1;
  assign pay_at_max  = (pay_inc == MAX_SIZE);
  assign short_frame = (byte_inc < MIN_SIZE);

  // Payload bytes bypass the registers so the pass-through adds no latency.
  assign s_tready       = in_pay ? tx_axis_tready : (state_q == DROP);
  assign tx_axis_tdata  = in_pay ? s_tdata : tdata_q;
  assign tx_axis_tvalid = in_pay ? s_tvalid : tvalid_q;
  assign tx_axis_tlast  = in_pay ? (pay_at_max | (s_tlast & ~short_frame)) : tlast_q;

  assign tx_xfer  = tx_axis_tvalid & tx_axis_tready;
  assign pay_xfer = in_pay & tx_xfer;

  assign frame_truncated = pay_xfer & pay_at_max & ~s_tlast;
  assign frame_done = (pay_xfer & s_tlast & ~short_frame)
                    | ((state_q == PAD) & tx_xfer & tlast_q)
                    | ((state_q == DROP) & s_tvalid & s_tlast);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    case (state_q)
      IDLE: begin
        if (enable_tx_encode && s_tvalid) begin
          state_d    = HEADER;
          byte_cnt_d = 16'd0;
          pay_cnt_d  = 16'd0;
          tdata_d    = hdr_byte(5'd0);
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
        end
      end
      HEADER: begin
        if (tx_xfer) begin
          byte_cnt_d = byte_inc;
          if (byte_cnt_q[4:0] == HDR_LEN - 5'd1) begin
            state_d  = PAYLOAD;
            tvalid_d = 1'b0;
            tdata_d  = 8'h00;
          end else begin
            tdata_d = hdr_byte(byte_cnt_q[4:0] + 5'd1);
          end
        end
      end
      PAYLOAD: begin
        if (tx_xfer) begin
          byte_cnt_d = byte_inc;
          pay_cnt_d  = pay_inc;
          if (pay_at_max && !s_tlast) begin
            state_d = DROP;
          end else if (s_tlast) begin
            if (!short_frame) begin
              state_d = IDLE;
            end else begin
              state_d  = PAD;
              tdata_d  = 8'h00;
              tvalid_d = 1'b1;
              tlast_d  = (byte_cnt_q + 16'd2 == MIN_SIZE);
            end
          end
        end
      end
      PAD: begin
        if (tx_xfer) begin
          byte_cnt_d = byte_inc;
          if (tlast_q) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            tlast_d = (byte_cnt_q + 16'd2 == MIN_SIZE);
          end
        end
      end
      DROP: begin
        if (s_tvalid && s_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      state_q    <= IDLE;
      byte_cnt_q <= 16'd0;
      pay_cnt_q  <= 16'd0;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

endmodule

// File: tb/tb_kc705_ethernet_rgmii_axi_tx_encoder.sv
// Randomized bench for the TX framer: two instances (MAX_SIZE=500 plain, VLAN default size),
// each frame compared against a queue-based model of header + clipped payload + zero pad.
module tb_kc705_ethernet_rgmii_axi_tx_encoder;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       enable;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       tready;
  logic       sel;
  int         tr_mode;

  logic [N-1:0] en_v, sv_v, rdy_v;
  logic [N-1:0] s_tready_v, tvalid_v, tlast_v, done_v, trunc_v;
  logic [7:0]   tdata_v [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      assign en_v[gi]  = enable & (sel == 1'(gi));
      assign sv_v[gi]  = s_tvalid & (sel == 1'(gi));
      assign rdy_v[gi] = tready & (sel == 1'(gi));
      kc705_ethernet_rgmii_axi_tx_encoder #(
        .MAX_SIZE    ((gi == 0) ? 16'd500 : 16'd1500),
        .ENABLE_VLAN ((gi == 1) ? 1'b1 : 1'b0)
      ) u_dut (
        .axi_tclk         (clk),
        .axi_treset       (rst),
        .enable_tx_encode (en_v[gi]),
        .s_tdata          (s_tdata),
        .s_tvalid         (sv_v[gi]),
        .s_tlast          (s_tlast),
        .s_tready         (s_tready_v[gi]),
        .tx_axis_tdata    (tdata_v[gi]),
        .tx_axis_tvalid   (tvalid_v[gi]),
        .tx_axis_tlast    (tlast_v[gi]),
        .tx_axis_tready   (rdy_v[gi]),
        .frame_done       (done_v[gi]),
        .frame_truncated  (trunc_v[gi])
      );
    end
  endgenerate

  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tready, m_s_tready, m_done, m_trunc;
  assign m_tdata    = tdata_v[sel];
  assign m_tvalid   = tvalid_v[sel];
  assign m_tlast    = tlast_v[sel];
  assign m_tready   = rdy_v[sel];
  assign m_s_tready = s_tready_v[sel];
  assign m_done     = done_v[sel];
  assign m_trunc    = trunc_v[sel];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Monitor state: all cumulative, frames take baselines.
  logic [7:0] cap_d[$];
  logic       cap_l[$];
  int cyc = 0, done_cnt = 0, trunc_cnt = 0, stall_err = 0, pad_err = 0, drop_err = 0;
  int tlast_cyc = 0, in_last_cyc = 0, done_cyc = 0;
  logic pad_flag = 1'b0, drop_flag = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic prev_l = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (pad_flag && m_s_tready) pad_err++;
      if (drop_flag && m_tvalid) drop_err++;
      if (prev_stall && (!m_tvalid || m_tdata != prev_d || m_tlast != prev_l)) stall_err++;
      if (m_tvalid && m_tready) begin
        cap_d.push_back(m_tdata);
        cap_l.push_back(m_tlast);
        if (m_tlast) tlast_cyc = cyc;
      end
      if (s_tvalid && m_s_tready && s_tlast) begin
        in_last_cyc = cyc;
        if (!m_done) pad_flag = 1'b1;
      end
      if (m_trunc) begin
        trunc_cnt++;
        drop_flag = 1'b1;
      end
      if (m_done) begin
        done_cnt++;
        done_cyc  = cyc;
        pad_flag  = 1'b0;
        drop_flag = 1'b0;
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
    end else begin
      prev_stall = 1'b0;
      pad_flag   = 1'b0;
      drop_flag  = 1'b0;
    end
  end

  // Downstream ready: 0 = always, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random.
  int rdy_pat [6];
  initial begin
    int pi;
    pi = 0;
    rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0;
    rdy_pat[3] = 1; rdy_pat[4] = 0; rdy_pat[5] = 1;
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        1: begin tready = rdy_pat[pi % 6] != 0; pi++; end
        2: tready = ($urandom_range(0, 2) != 0);
        default: tready = 1'b1;
      endcase
    end
  end

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];

  task automatic push_bytes(input logic [63:0] v, input int nbytes);
    for (int k = nbytes - 1; k >= 0; k--) exp_q.push_back(8'(v >> (8 * k)));
  endtask

  task automatic build_expected(input logic vlan, input int max_size, output int trunc);
    int use_n;
    exp_q.delete();
    push_bytes(64'h985aebdb066f, 6);
    push_bytes(64'h5a0102030405, 6);
    if (vlan) begin
      push_bytes(64'h8100, 2);
      push_bytes(64'((3'd2 << 13) | 12'd2), 2);
    end
    push_bytes(64'h0800, 2);
    trunc = (pay_q.size() > max_size) ? 1 : 0;
    use_n = trunc ? max_size : pay_q.size();
    for (int i = 0; i < use_n; i++) exp_q.push_back(pay_q[i]);
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
  endtask

  task automatic run_frame(input string tag, input logic s, input int n, input int pat,
                           input int mode, input int gaps);
    int exp_trunc, b_cap, b_done, b_trunc, b_stall, b_pad, b_drop, waitc, ncmp, bad_b, bad_l;
    logic acc;
    sel = s;
    tr_mode = mode;
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back((pat == 0) ? 8'(i) : 8'($urandom));
    build_expected(s, (s == 1'b0) ? 500 : 1500, exp_trunc);
    b_cap = cap_d.size(); b_done = done_cnt; b_trunc = trunc_cnt;
    b_stall = stall_err; b_pad = pad_err; b_drop = drop_err;
    enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps != 0 && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_tdata  = pay_q[i];
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      waitc = 0;
      do begin
        @(negedge clk);
        acc = m_s_tready;
        @(posedge clk);
        #1;
        waitc++;
      end while (!acc && waitc < 2000);
      if (!acc) begin
        check_val({tag, " input_timeout"}, i, n);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    waitc = 0;
    while (done_cnt == b_done && waitc < 3000) begin
      @(posedge clk);
      waitc++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, " len"}, cap_d.size() - b_cap, exp_q.size());
    ncmp = cap_d.size() - b_cap;
    if (ncmp > exp_q.size()) ncmp = exp_q.size();
    bad_b = 0; bad_l = 0;
    for (int i = 0; i < ncmp; i++) begin
      if (cap_d[b_cap + i] != exp_q[i]) begin
        if (bad_b == 0) check_val({tag, " first_bad_byte"}, cap_d[b_cap + i], exp_q[i]);
        bad_b++;
      end
      if (cap_l[b_cap + i] != (i == exp_q.size() - 1)) bad_l++;
    end
    check_val({tag, " byte0"}, (ncmp > 0) ? cap_d[b_cap] : -1, 8'h98);
    check_val({tag, " bad_bytes"}, bad_b, 0);
    check_val({tag, " bad_tlast"}, bad_l, 0);
    check_val({tag, " done_cnt"}, done_cnt - b_done, 1);
    check_val({tag, " trunc_cnt"}, trunc_cnt - b_trunc, exp_trunc);
    check_val({tag, " done_cycle"}, done_cyc, exp_trunc ? in_last_cyc : tlast_cyc);
    check_val({tag, " stall_stable"}, stall_err - b_stall, 0);
    check_val({tag, " pad_ready"}, pad_err - b_pad, 0);
    check_val({tag, " drop_valid"}, drop_err - b_drop, 0);
    $display("[TB] frame %s inst=%0d payload=%0d out=%0d trunc=%0d", tag, s, n,
             cap_d.size() - b_cap, exp_trunc);
  endtask

  initial begin
    int b_cap, waitc, bad;
    sel = 1'b0; tr_mode = 0; enable = 1'b0;
    s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst tvalid", m_tvalid, 0);
    check_val("rst tdata", m_tdata, 0);
    check_val("rst s_tready", m_s_tready, 0);
    check_val("rst tlast", m_tlast, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame("t1_min46", 1'b0, 46, 0, 0, 0);
    run_frame("t2_pad10", 1'b0, 10, 0, 0, 0);
    run_frame("t3_trunc600", 1'b0, 600, 0, 0, 0);
    run_frame("t3_next", 1'b0, 20, 1, 0, 0);
    run_frame("t4_vlan10", 1'b1, 10, 0, 0, 0);
    run_frame("t5_stall46", 1'b0, 46, 0, 1, 0);
    run_frame("b_max500", 1'b0, 500, 1, 2, 0);
    run_frame("b_max501", 1'b0, 501, 1, 2, 0);
    run_frame("b_47", 1'b0, 47, 1, 1, 1);
    run_frame("b_45", 1'b0, 45, 1, 1, 1);
    run_frame("b_1", 1'b0, 1, 1, 2, 1);
    run_frame("b_vlan42", 1'b1, 42, 1, 2, 1);
    run_frame("b_vlan41", 1'b1, 41, 1, 1, 1);
    for (int r = 0; r < 10; r++) run_frame($sformatf("rnd_a%0d", r), 1'b0,
                                          $urandom_range(1, 520), 1, 2, 1);
    for (int r = 0; r < 6; r++) run_frame($sformatf("rnd_v%0d", r), 1'b1,
                                         $urandom_range(1, 80), 1, 2, 1);

    // Mid-frame asynchronous reset on output byte 20.
    sel = 1'b0; tr_mode = 0; enable = 1'b1;
    s_tdata = 8'h55; s_tlast = 1'b0; s_tvalid = 1'b1;
    b_cap = cap_d.size();
    waitc = 0;
    do begin
      @(posedge clk);
      waitc++;
    end while (cap_d.size() - b_cap != 19 && waitc < 200);
    check_val("rst_mid reached", cap_d.size() - b_cap, 19);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_mid tvalid", m_tvalid, 0);
    check_val("rst_mid tlast", m_tlast, 0);
    check_val("rst_mid tdata", m_tdata, 0);
    check_val("rst_mid s_tready", m_s_tready, 0);
    check_val("rst_mid done", m_done, 0);
    check_val("rst_mid trunc", m_trunc, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    s_tvalid = 1'b1;
    b_cap = cap_d.size();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (m_s_tready || m_tvalid) bad++;
    end
    check_val("disabled no_activity", bad, 0);
    check_val("disabled no_bytes", cap_d.size() - b_cap, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    run_frame("after_rst", 1'b0, 30, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
